// File: rtl/dmac_cfg_pkg.sv
// ---------------------------------------------------------------------------
// dmac_cfg_pkg
// Shared definitions for the DMAC configuration/status register file:
//   - register offsets (global and per-channel)
//   - STATUS / CMD bit positions
//   - ch_cfg_t: per-channel {src, dst, len} bundle handed to the engine
//   - helpers for channel-local offset decode and byte-lane merging
// ---------------------------------------------------------------------------
package dmac_cfg_pkg;

  // Global registers
  localparam int OFS_VERSION   = 'h000;
  localparam int OFS_IE        = 'h004;

  // Channel window: channel c lives at OFS_CH_BASE + c*OFS_CH_STRIDE
  localparam int CH_STRIDE_SH  = 5;
  localparam int OFS_CH_BASE   = 'h100;
  localparam int OFS_CH_STRIDE = 1 << CH_STRIDE_SH;

  // Offsets inside one channel window
  localparam int OFS_SRC       = 'h00;
  localparam int OFS_DST       = 'h04;
  localparam int OFS_LEN       = 'h08;
  localparam int OFS_CMD       = 'h0C;
  localparam int OFS_STATUS    = 'h10;

  // Bit positions
  localparam int CMD_START_BIT = 0;
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;

  // len is carried at full word width; the channel zero-extends its LEN_W field
  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
  } ch_cfg_t;

  typedef enum logic [2:0] {
    REG_SRC,
    REG_DST,
    REG_LEN,
    REG_CMD,
    REG_STATUS,
    REG_NONE
  } ch_reg_e;

  // Map a channel-local byte offset to the register it selects
  function automatic ch_reg_e decode_ch_reg(input logic [CH_STRIDE_SH-1:0] ofs);
    case (ofs)
      CH_STRIDE_SH'(OFS_SRC):    return REG_SRC;
      CH_STRIDE_SH'(OFS_DST):    return REG_DST;
      CH_STRIDE_SH'(OFS_LEN):    return REG_LEN;
      CH_STRIDE_SH'(OFS_CMD):    return REG_CMD;
      CH_STRIDE_SH'(OFS_STATUS): return REG_STATUS;
      default:                   return REG_NONE;
    endcase
  endfunction

  // Replace only the byte lanes whose strobe is set
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmac_cfg_ch.sv
// ---------------------------------------------------------------------------
// dmac_cfg_ch
// One DMA channel's register set: SRC, DST, LEN plus busy/done tracking and
// the one-cycle start pulse. All access legality is decided by the parent;
// the strobes arriving here are already qualified, so this block just acts.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-high reset
//   i_wr_src/dst/len  commit a write to the corresponding register
//   i_start        accepted start command (busy <= 1, start pulse next cycle)
//   i_w1c          clear done (loses to a simultaneous i_done)
//   i_done         completion pulse from the engine
//   i_wdata        write data, i_wstrb byte-lane enables
//   o_cfg          {src, dst, len} toward the engine
//   o_busy/o_done  status bits
//   o_start        registered start pulse
//   o_len_zero     LEN currently 0 (start must be refused)
// ---------------------------------------------------------------------------
module dmac_cfg_ch
  import dmac_cfg_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wr_src,
  input  logic        i_wr_dst,
  input  logic        i_wr_len,
  input  logic        i_start,
  input  logic        i_w1c,
  input  logic        i_done,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output ch_cfg_t     o_cfg,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_start,
  output logic        o_len_zero
);

  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_len;
  logic             r_busy;
  logic             r_done;
  logic             r_start;
  logic [LEN_W-1:0] w_len_merged;

  // LEN is narrower than a word, so merge per bit using the lane of each bit
  always_comb begin
    w_len_merged = r_len;
    for (int b = 0; b < LEN_W; b++) begin
      if (i_wstrb[b/8]) w_len_merged[b] = i_wdata[b];
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_start <= 1'b0;
    end else begin
      if (i_wr_src) r_src <= merge_bytes(r_src, i_wdata, i_wstrb);
      if (i_wr_dst) r_dst <= merge_bytes(r_dst, i_wdata, i_wstrb);
      if (i_wr_len) r_len <= w_len_merged;

      r_start <= i_start;

      // A start is only ever accepted while idle; if a stray done arrives on
      // that same edge it cannot belong to the new transfer, so start wins.
      if (i_start)     r_busy <= 1'b1;
      else if (i_done) r_busy <= 1'b0;

      // Set beats clear so a completion is never lost to a racing W1C
      if (i_done)     r_done <= 1'b1;
      else if (i_w1c) r_done <= 1'b0;
    end
  end

  assign o_cfg      = {r_src, r_dst, 32'(r_len)};
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_start    = r_start;
  assign o_len_zero = (r_len == '0);

endmodule

// File: rtl/dmac_cfg_regs.sv
// ---------------------------------------------------------------------------
// dmac_cfg_regs
// Multi-channel DMAC configuration/status register file with an APB3 slave.
// Holds APB decode, the registered read mux, the IE register and the level
// interrupt; per-channel state lives in N_CH dmac_cfg_ch instances.
//
// Build option: define DMAC_CFG_PSTRB_EN to add pstrb_i byte strobes.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-high reset
//   psel_i .. pwdata_i    APB3 request (paddr_i[1:0] ignored)
//   pstrb_i               byte strobes (only with DMAC_CFG_PSTRB_EN)
//   pready_o              always 1 (zero wait states)
//   prdata_o, pslverr_o   registered in setup, valid in access phase
//   src_o/dst_o/len_o     flattened per-channel configuration
//   start_o               one-cycle start pulse per channel
//   done_i                one-cycle completion pulse per channel
//   irq_o                 registered |(done & IE)
// ---------------------------------------------------------------------------
module dmac_cfg_regs
  import dmac_cfg_pkg::*;
#(
  parameter int          N_CH    = 4,
  parameter int          ADDR_W  = 12,
  parameter int          LEN_W   = 16,
  parameter logic [31:0] VERSION = 32'h0002_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic [ADDR_W-1:0]     paddr_i,
  input  logic                  pwrite_i,
  input  logic [31:0]           pwdata_i,
`ifdef DMAC_CFG_PSTRB_EN
  input  logic [3:0]            pstrb_i,
`endif
  output logic                  pready_o,
  output logic [31:0]           prdata_o,
  output logic                  pslverr_o,
  output logic [N_CH*32-1:0]    src_o,
  output logic [N_CH*32-1:0]    dst_o,
  output logic [N_CH*LEN_W-1:0] len_o,
  output logic [N_CH-1:0]       start_o,
  input  logic [N_CH-1:0]       done_i,
  output logic                  irq_o
);

  localparam int IDX_W = ADDR_W - CH_STRIDE_SH;

  logic [ADDR_W-1:0]     w_addr;
  logic [ADDR_W-1:0]     w_ch_off;
  logic [IDX_W-1:0]      w_ch_idx;
  logic                  w_in_ch;
  logic                  w_ch_ok;
  ch_reg_e               w_reg;
  logic [3:0]            w_strb;
  logic                  w_lane0;
  logic                  w_unused_addr;

  logic [N_CH-1:0]       w_hit;
  logic [N_CH-1:0]       w_busy;
  logic [N_CH-1:0]       w_done;
  logic [N_CH-1:0]       w_len_zero;
  ch_cfg_t [N_CH-1:0]    w_cfg;

  ch_cfg_t               w_sel_cfg;
  logic                  w_sel_busy;
  logic                  w_sel_done;
  logic                  w_sel_len_zero;

  logic                  w_err;
  logic                  w_wr_ie;
  logic                  w_wr_src;
  logic                  w_wr_dst;
  logic                  w_wr_len;
  logic                  w_do_start;
  logic                  w_do_w1c;
  logic [31:0]           w_rdata;
  logic                  w_setup;
  logic                  w_commit;

  logic [N_CH-1:0]       r_ie;
  logic                  r_irq;
  logic [31:0]           r_prdata;
  logic                  r_pslverr;

`ifdef DMAC_CFG_PSTRB_EN
  assign w_strb = pstrb_i;
`else
  assign w_strb = 4'hF;
`endif
  assign w_lane0 = w_strb[0];

  // ---------------- address decode ----------------
  assign w_addr        = {paddr_i[ADDR_W-1:2], 2'b00};
  assign w_unused_addr = ^paddr_i[1:0];
  assign w_in_ch       = (w_addr >= ADDR_W'(OFS_CH_BASE));
  assign w_ch_off      = w_addr - ADDR_W'(OFS_CH_BASE);
  assign w_ch_idx      = w_ch_off[ADDR_W-1:CH_STRIDE_SH];
  assign w_ch_ok       = w_in_ch && (w_ch_idx < IDX_W'(N_CH));
  assign w_reg         = decode_ch_reg(w_ch_off[CH_STRIDE_SH-1:0]);

  // Select the addressed channel's state (w_hit is one-hot or zero)
  always_comb begin
    w_sel_cfg      = '0;
    w_sel_busy     = 1'b0;
    w_sel_done     = 1'b0;
    w_sel_len_zero = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (w_hit[c]) begin
        w_sel_cfg      = w_cfg[c];
        w_sel_busy     = w_busy[c];
        w_sel_done     = w_done[c];
        w_sel_len_zero = w_len_zero[c];
      end
    end
  end

  // ---------------- access legality ----------------
  // Evaluated in both phases from current (pre-edge) state: the setup phase
  // registers it as pslverr, the access phase uses it to gate the commit.
  always_comb begin
    w_err      = 1'b0;
    w_wr_ie    = 1'b0;
    w_wr_src   = 1'b0;
    w_wr_dst   = 1'b0;
    w_wr_len   = 1'b0;
    w_do_start = 1'b0;
    w_do_w1c   = 1'b0;
    if (w_addr == ADDR_W'(OFS_VERSION)) begin
      w_err = pwrite_i;
    end else if (w_addr == ADDR_W'(OFS_IE)) begin
      w_wr_ie = pwrite_i;
    end else if (!w_ch_ok) begin
      w_err = 1'b1;
    end else if (pwrite_i) begin
      case (w_reg)
        REG_SRC, REG_DST, REG_LEN: begin
          if (w_sel_busy) begin
            w_err = 1'b1;
          end else begin
            w_wr_src = (w_reg == REG_SRC);
            w_wr_dst = (w_reg == REG_DST);
            w_wr_len = (w_reg == REG_LEN);
          end
        end
        REG_CMD: begin
          if (w_lane0 && pwdata_i[CMD_START_BIT]) begin
            if (w_sel_busy || w_sel_len_zero) w_err = 1'b1;
            else                              w_do_start = 1'b1;
          end
        end
        REG_STATUS: begin
          // busy is read-only; a write that only touches it is an error
          if (w_lane0) begin
            if (pwdata_i[STAT_DONE_BIT])      w_do_w1c = 1'b1;
            else if (pwdata_i[STAT_BUSY_BIT]) w_err    = 1'b1;
          end
        end
        default: w_err = 1'b1;
      endcase
    end else if (w_reg == REG_NONE) begin
      w_err = 1'b1;
    end
  end

  assign w_setup  = psel_i && !penable_i;
  assign w_commit = psel_i && penable_i && pwrite_i && !w_err;

  // ---------------- read mux ----------------
  always_comb begin
    w_rdata = '0;
    if (w_addr == ADDR_W'(OFS_VERSION)) begin
      w_rdata = VERSION;
    end else if (w_addr == ADDR_W'(OFS_IE)) begin
      w_rdata = 32'(r_ie);
    end else if (w_ch_ok) begin
      case (w_reg)
        REG_SRC: w_rdata = w_sel_cfg.src;
        REG_DST: w_rdata = w_sel_cfg.dst;
        REG_LEN: w_rdata = w_sel_cfg.len;
        REG_STATUS: begin
          w_rdata[STAT_BUSY_BIT] = w_sel_busy;
          w_rdata[STAT_DONE_BIT] = w_sel_done;
        end
        default: w_rdata = '0;
      endcase
    end
  end

  // ---------------- APB response, IE, irq ----------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_ie      <= '0;
      r_irq     <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      // Loaded in setup, held through access, then dropped back to 0
      if (w_setup) begin
        r_pslverr <= w_err;
        r_prdata  <= (w_err || pwrite_i) ? 32'h0 : w_rdata;
      end else begin
        r_pslverr <= 1'b0;
        r_prdata  <= '0;
      end
      if (w_commit && w_wr_ie && w_lane0) r_ie <= pwdata_i[N_CH-1:0];
      r_irq <= |(w_done & r_ie);
    end
  end

  // ---------------- channels ----------------
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign w_hit[gi] = w_ch_ok && (w_ch_idx == IDX_W'(gi));

    dmac_cfg_ch #(
      .LEN_W (LEN_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_src   (w_commit && w_hit[gi] && w_wr_src),
      .i_wr_dst   (w_commit && w_hit[gi] && w_wr_dst),
      .i_wr_len   (w_commit && w_hit[gi] && w_wr_len),
      .i_start    (w_commit && w_hit[gi] && w_do_start),
      .i_w1c      (w_commit && w_hit[gi] && w_do_w1c),
      .i_done     (done_i[gi]),
      .i_wdata    (pwdata_i),
      .i_wstrb    (w_strb),
      .o_cfg      (w_cfg[gi]),
      .o_busy     (w_busy[gi]),
      .o_done     (w_done[gi]),
      .o_start    (start_o[gi]),
      .o_len_zero (w_len_zero[gi])
    );

    assign src_o[gi*32 +: 32]       = w_cfg[gi].src;
    assign dst_o[gi*32 +: 32]       = w_cfg[gi].dst;
    assign len_o[gi*LEN_W +: LEN_W] = w_cfg[gi].len[LEN_W-1:0];
  end

  assign pready_o  = 1'b1;
  assign prdata_o  = r_prdata;
  assign pslverr_o = r_pslverr;
  assign irq_o     = r_irq;

endmodule

// File: tb/tb_dmac_cfg_regs.sv
// ---------------------------------------------------------------------------
// tb_dmac_cfg_regs
// Directed self-checking bench for dmac_cfg_regs (default build, 4 channels).
// ---------------------------------------------------------------------------
module tb_dmac_cfg_regs;

  localparam int N_CH   = 4;
  localparam int ADDR_W = 12;
  localparam int LEN_W  = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  psel_i = 1'b0;
  logic                  penable_i = 1'b0;
  logic [ADDR_W-1:0]     paddr_i = '0;
  logic                  pwrite_i = 1'b0;
  logic [31:0]           pwdata_i = '0;
  logic                  pready_o;
  logic [31:0]           prdata_o;
  logic                  pslverr_o;
  logic [N_CH*32-1:0]    src_o;
  logic [N_CH*32-1:0]    dst_o;
  logic [N_CH*LEN_W-1:0] len_o;
  logic [N_CH-1:0]       start_o;
  logic [N_CH-1:0]       done_i = '0;
  logic                  irq_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] rd;
  logic        er;

  dmac_cfg_regs #(
    .N_CH    (N_CH),
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W),
    .VERSION (32'h0002_0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .psel_i    (psel_i),
    .penable_i (penable_i),
    .paddr_i   (paddr_i),
    .pwrite_i  (pwrite_i),
    .pwdata_i  (pwdata_i),
    .pready_o  (pready_o),
    .prdata_o  (prdata_o),
    .pslverr_o (pslverr_o),
    .src_o     (src_o),
    .dst_o     (dst_o),
    .len_o     (len_o),
    .start_o   (start_o),
    .done_i    (done_i),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One APB transfer; dn is driven on done_i during the access cycle so it
  // lands on the same edge as the commit. Returns 1 time unit after that edge.
  task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d,
                     input logic [3:0] dn, output logic [31:0] rdata, output logic err);
    @(posedge clk); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = a; pwdata_i = d;
    @(posedge clk); #1;
    penable_i = 1'b1; done_i = dn;
    @(negedge clk);
    rdata = prdata_o; err = pslverr_o;
    @(posedge clk); #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; done_i = '0;
  endtask

  initial begin
    // ---- reset ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst_src",    src_o[31:0], 32'h0);
    chk("rst_start",  32'(start_o), 32'h0);
    chk("rst_irq",    32'(irq_o), 32'h0);
    chk("rst_prdata", prdata_o, 32'h0);
    chk("rst_pslverr", 32'(pslverr_o), 32'h0);
    chk("pready",     32'(pready_o), 32'h1);
    rst_n = 1'b0;

    // ---- basic reads ----
    apb(1'b0, 12'h000, 32'h0, 4'h0, rd, er);
    chk("ver_rd", rd, 32'h0002_0000);
    chk("ver_err", 32'(er), 32'h0);
    chk("prdata_idle", prdata_o, 32'h0);
    apb(1'b0, 12'h104, 32'h0, 4'h0, rd, er);
    chk("ch0_dst_rd", rd, 32'h0);
    chk("ch0_dst_err", 32'(er), 32'h0);

    // ---- program ch1 and start ----
    apb(1'b1, 12'h120, 32'h1000_0000, 4'h0, rd, er);
    chk("src_wr_err", 32'(er), 32'h0);
    apb(1'b1, 12'h124, 32'h2000_0000, 4'h0, rd, er);
    apb(1'b1, 12'h128, 32'h0000_0040, 4'h0, rd, er);
    chk("ch1_src", src_o[63:32], 32'h1000_0000);
    chk("ch1_dst", dst_o[63:32], 32'h2000_0000);
    chk("ch1_len", 32'(len_o[31:16]), 32'h0040);
    apb(1'b1, 12'h12C, 32'h1, 4'h0, rd, er);
    chk("cmd_err", 32'(er), 32'h0);
    chk("start_pulse", 32'(start_o), 32'h2);
    @(posedge clk); #1;
    chk("start_gone", 32'(start_o), 32'h0);
    apb(1'b0, 12'h130, 32'h0, 4'h0, rd, er);
    chk("ch1_status_busy", rd, 32'h1);

    // ---- busy protections ----
    apb(1'b1, 12'h120, 32'hDEAD_BEEF, 4'h0, rd, er);
    chk("src_busy_err", 32'(er), 32'h1);
    chk("src_busy_keep", src_o[63:32], 32'h1000_0000);
    apb(1'b1, 12'h12C, 32'h1, 4'h0, rd, er);
    chk("cmd_busy_err", 32'(er), 32'h1);
    chk("cmd_busy_nostart", 32'(start_o), 32'h0);

    // ---- done / irq / W1C ----
    apb(1'b1, 12'h004, 32'h2, 4'h0, rd, er);
    chk("ie_wr_err", 32'(er), 32'h0);
    done_i = 4'b0010;
    @(posedge clk); #1;
    done_i = 4'b0000;
    chk("irq_lag", 32'(irq_o), 32'h0);
    @(posedge clk); #1;
    chk("irq_set", 32'(irq_o), 32'h1);
    apb(1'b0, 12'h130, 32'h0, 4'h0, rd, er);
    chk("ch1_status_done", rd, 32'h2);
    apb(1'b1, 12'h130, 32'h2, 4'h0, rd, er);
    chk("w1c_err", 32'(er), 32'h0);
    @(posedge clk); #1;
    chk("irq_clr", 32'(irq_o), 32'h0);

    // ---- W1C racing done on ch2: done wins ----
    apb(1'b1, 12'h150, 32'h2, 4'b0100, rd, er);
    apb(1'b0, 12'h150, 32'h0, 4'h0, rd, er);
    chk("ch2_w1c_race", rd, 32'h2);
    chk("irq_masked", 32'(irq_o), 32'h0);

    // ---- error cases ----
    apb(1'b1, 12'h14C, 32'h1, 4'h0, rd, er);
    chk("len0_err", 32'(er), 32'h1);
    chk("len0_nostart", 32'(start_o), 32'h0);
    apb(1'b0, 12'h300, 32'h0, 4'h0, rd, er);
    chk("unmap300_err", 32'(er), 32'h1);
    chk("unmap300_rd", rd, 32'h0);
    apb(1'b0, 12'h180, 32'h0, 4'h0, rd, er);
    chk("ch4_err", 32'(er), 32'h1);
    apb(1'b0, 12'h008, 32'h0, 4'h0, rd, er);
    chk("unmap008_err", 32'(er), 32'h1);
    apb(1'b0, 12'h11C, 32'h0, 4'h0, rd, er);
    chk("unmap11c_err", 32'(er), 32'h1);
    apb(1'b1, 12'h000, 32'h1234_5678, 4'h0, rd, er);
    chk("ver_wr_err", 32'(er), 32'h1);
    apb(1'b1, 12'h110, 32'h1, 4'h0, rd, er);
    chk("busy_wr_err", 32'(er), 32'h1);
    apb(1'b0, 12'h004, 32'h0, 4'h0, rd, er);
    chk("ie_rd", rd, 32'h2);

    // ---- done while idle on ch0 ----
    done_i = 4'b0001;
    @(posedge clk); #1;
    done_i = 4'b0000;
    apb(1'b0, 12'h110, 32'h0, 4'h0, rd, er);
    chk("ch0_idle_done", rd, 32'h2);

    // ---- restart ch1, then CMD racing done ----
    apb(1'b1, 12'h12C, 32'h1, 4'h0, rd, er);
    chk("restart_err", 32'(er), 32'h0);
    chk("restart_pulse", 32'(start_o), 32'h2);
    apb(1'b1, 12'h12C, 32'h1, 4'b0010, rd, er);
    chk("cmd_done_race_err", 32'(er), 32'h1);
    chk("cmd_done_race_nostart", 32'(start_o), 32'h0);
    apb(1'b0, 12'h130, 32'h0, 4'h0, rd, er);
    chk("cmd_done_race_status", rd, 32'h2);
    chk("irq_pre_rst", 32'(irq_o), 32'h1);

    // ---- reset during a CMD access phase on ch3 ----
    apb(1'b1, 12'h160, 32'h3000_0000, 4'h0, rd, er);
    apb(1'b1, 12'h168, 32'h4, 4'h0, rd, er);
    @(posedge clk); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 12'h16C; pwdata_i = 32'h1;
    @(posedge clk); #1;
    penable_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_src3", src_o[127:96], 32'h0);
    chk("rst_mid_src1", src_o[63:32], 32'h0);
    chk("rst_mid_len", len_o[63:32], 32'h0);
    chk("rst_mid_irq", 32'(irq_o), 32'h0);
    chk("rst_mid_err", 32'(pslverr_o), 32'h0);
    @(posedge clk); #1;
    chk("rst_mid_nostart", 32'(start_o), 32'h0);
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_post_nostart", 32'(start_o), 32'h0);
    apb(1'b0, 12'h130, 32'h0, 4'h0, rd, er);
    chk("rst_post_status", rd, 32'h0);
    apb(1'b0, 12'h004, 32'h0, 4'h0, rd, er);
    chk("rst_post_ie", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
